// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic array edge feeder: default geometry, FSM states
// and job phase lengths.
package tpu_pkg;

    localparam int unsigned DEFAULT_N          = 4;
    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;

    // 2N-1 wavefronts cover every skewed diagonal of an N x N operand.
    function automatic int unsigned feed_cycles(input int unsigned n);
        return 2 * n - 1;
    endfunction

    // Last wavefront needs N hops to reach PE(N-1,N-1) and settle in its register.
    function automatic int unsigned drain_cycles(input int unsigned n);
        return n;
    endfunction

    localparam int unsigned FEED_CYCLES  = feed_cycles(DEFAULT_N);
    localparam int unsigned DRAIN_CYCLES = drain_cycles(DEFAULT_N);

endpackage

// File: rtl/skew_lane.sv
// One skewed edge lane: selects operand (t - LANE) from the lane's N latched operands,
// or drives zero while the lane's diagonal is outside the operand range.
module skew_lane
    import tpu_pkg::*;
#(
    parameter int unsigned N          = DEFAULT_N,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned LANE       = 0,
    parameter int unsigned TW         = $clog2(2 * N)
) (
    input  logic [TW-1:0]           i_t,
    input  logic [N*DATA_WIDTH-1:0] i_ops,
    output logic [DATA_WIDTH-1:0]   o_data
);

    always_comb begin
        o_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (32'(i_t) == LANE + k) begin
                o_data = i_ops[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/systolic_input_feeder.sv
// Edge driver for the output-stationary systolic array: captures A and B on start,
// streams skewed wavefronts into the row/column edges, drains, then pulses done.
module systolic_input_feeder
    import tpu_pkg::*;
#(
    parameter int unsigned N          = DEFAULT_N,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [N*N*DATA_WIDTH-1:0] a_flat,
    input  logic [N*N*DATA_WIDTH-1:0] b_flat,
    output logic [N*DATA_WIDTH-1:0]   x_edge,
    output logic [N*DATA_WIDTH-1:0]   y_edge,
    output logic                      valid,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned VW = N * DATA_WIDTH;
    localparam int unsigned MW = N * VW;
    localparam int unsigned TW = $clog2(2 * N);
    localparam logic [TW-1:0] LAST_FEED  = TW'(feed_cycles(N) - 1);
    localparam logic [TW-1:0] LAST_DRAIN = TW'(drain_cycles(N) - 1);

    feeder_state_t r_state;
    logic [TW-1:0] r_t;
    logic [MW-1:0] r_a;
    logic [MW-1:0] r_b;
    logic [VW-1:0] r_x;
    logic [VW-1:0] r_y;
    logic          r_valid;
    logic          r_busy;
    logic          r_done;

    logic                                w_accept;
    logic [N-1:0][VW-1:0]                w_b_cols;
    logic [N-1:0][DATA_WIDTH-1:0]        w_x;
    logic [N-1:0][DATA_WIDTH-1:0]        w_y;

    assign w_accept = start && (r_state == IDLE || r_state == DONE);

    // Operand capture needs no reset: contents are only read after an acceptance.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= a_flat;
            r_b <= b_flat;
        end
    end

    // Row lanes read A rows directly; column lanes gather B[k][j] down each column.
    for (genvar g = 0; g < N; g++) begin : g_lane
        for (genvar k = 0; k < N; k++) begin : g_col
            assign w_b_cols[g][k*DATA_WIDTH +: DATA_WIDTH] =
                r_b[(k*N+g)*DATA_WIDTH +: DATA_WIDTH];
        end

        skew_lane #(
            .N          (N),
            .DATA_WIDTH (DATA_WIDTH),
            .LANE       (g),
            .TW         (TW)
        ) u_x_lane (
            .i_t    (r_t),
            .i_ops  (r_a[g*VW +: VW]),
            .o_data (w_x[g])
        );

        skew_lane #(
            .N          (N),
            .DATA_WIDTH (DATA_WIDTH),
            .LANE       (g),
            .TW         (TW)
        ) u_y_lane (
            .i_t    (r_t),
            .i_ops  (w_b_cols[g]),
            .o_data (w_y[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_t     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_x     <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    if (start) begin
                        r_state <= FEED;
                        r_t     <= '0;
                    end
                end
                FEED: begin
                    r_x     <= w_x;
                    r_y     <= w_y;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b1;
                    if (r_t == LAST_FEED) begin
                        r_state <= DRAIN;
                        r_t     <= '0;
                    end else begin
                        r_t <= r_t + 1'b1;
                    end
                end
                DRAIN: begin
                    r_busy <= 1'b1;
                    if (r_t == LAST_DRAIN) begin
                        r_state <= DONE;
                        r_t     <= '0;
                    end else begin
                        r_t <= r_t + 1'b1;
                    end
                end
                DONE: begin
                    r_busy <= 1'b1;
                    r_done <= 1'b1;
                    r_t    <= '0;
                    r_state <= start ? FEED : IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_t     <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign x_edge = r_x;
    assign y_edge = r_y;
    assign valid  = r_valid;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Bench for systolic_input_feeder: directed and random jobs checked cycle by cycle
// against a matrix-level model, plus a behavioural array that must reproduce A*B.
module tb_systolic_input_feeder;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int VW = N * DW;
    localparam int MW = N * N * DW;
    localparam int NW = 2 * N - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [MW-1:0] a_flat;
    logic [MW-1:0] b_flat;
    logic [VW-1:0] x_edge;
    logic [VW-1:0] y_edge;
    logic          valid;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;

    int ca [N][N];
    int cb [N][N];
    int na [N][N];
    int nb [N][N];
    int xo [NW][N];
    int yo [NW][N];

    always #5 clk = ~clk;

    systolic_input_feeder #(
        .N          (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_flat (a_flat),
        .b_flat (b_flat),
        .x_edge (x_edge),
        .y_edge (y_edge),
        .valid  (valid),
        .busy   (busy),
        .done   (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: random, 1: identity A with B[k][j]=4k+j+1, 2: all 0xFF
    task automatic rand_next(input int mode);
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                case (mode)
                    1: begin
                        na[i][k] = (i == k) ? 1 : 0;
                        nb[i][k] = N * i + k + 1;
                    end
                    2: begin
                        na[i][k] = 255;
                        nb[i][k] = 255;
                    end
                    default: begin
                        na[i][k] = int'($urandom_range(0, 255));
                        nb[i][k] = int'($urandom_range(0, 255));
                    end
                endcase
            end
        end
    endtask

    task automatic drive_next();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                a_flat[(i*N+k)*DW +: DW] = DW'(na[i][k]);
                b_flat[(i*N+k)*DW +: DW] = DW'(nb[i][k]);
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " x"}, 64'(x_edge), 64'd0);
        check({tag, " y"}, 64'(y_edge), 64'd0);
        check({tag, " valid"}, 64'(valid), 64'd0);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
    endtask

    // accepted: the acceptance edge already happened at the end of the previous job.
    // hold: keep start high throughout and chain a fresh random job at the done edge.
    task automatic run_job(input bit accepted, input bit hold, input bit corrupt,
                           input bit poke, input string name);
        logic [VW-1:0] ex;
        logic [VW-1:0] ey;
        int t;
        int sum;
        int ref_c;
        if (!accepted) begin
            drive_next();
            start = 1'b1;
            step();
        end
        ca = na;
        cb = nb;
        if (!hold) start = 1'b0;
        if (corrupt) begin
            a_flat = '1;
            b_flat = '1;
        end
        for (int k = 1; k <= 3 * N; k++) begin
            if (hold && k == 3 * N) begin
                rand_next(0);
                drive_next();
            end
            if (poke && k == 2 * N + 1) begin
                start  = 1'b1;
                a_flat = {$urandom, $urandom, $urandom, $urandom};
            end
            if (poke && k == 3 * N) start = 1'b0;
            step();
            ex = '0;
            ey = '0;
            if (k <= NW) begin
                t = k - 1;
                for (int l = 0; l < N; l++) begin
                    if (t - l >= 0 && t - l < N) begin
                        ex[l*DW +: DW] = DW'(ca[l][t-l]);
                        ey[l*DW +: DW] = DW'(cb[t-l][l]);
                    end
                    xo[t][l] = int'(x_edge[l*DW +: DW]);
                    yo[t][l] = int'(y_edge[l*DW +: DW]);
                end
            end
            check($sformatf("%s k%0d x", name, k), 64'(x_edge), 64'(ex));
            check($sformatf("%s k%0d y", name, k), 64'(y_edge), 64'(ey));
            check($sformatf("%s k%0d valid", name, k), 64'(valid), 64'(k <= NW));
            check($sformatf("%s k%0d busy", name, k), 64'(busy), 64'd1);
            check($sformatf("%s k%0d done", name, k), 64'(done), 64'(k == 3 * N));
        end
        // PE(i,j) sees x lane i delayed j hops and y lane j delayed i hops.
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                sum   = 0;
                ref_c = 0;
                for (int s = 0; s <= 3 * N; s++) begin
                    if (s - j >= 0 && s - j < NW && s - i >= 0 && s - i < NW)
                        sum += xo[s-j][i] * yo[s-i][j];
                end
                for (int m = 0; m < N; m++) ref_c += ca[i][m] * cb[m][j];
                check($sformatf("%s C[%0d][%0d]", name, i, j), 64'(sum), 64'(ref_c));
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        a_flat = '0;
        b_flat = '0;
        step();
        step();
        check_outputs_zero("reset");
        rst = 1'b0;
        step();
        check_outputs_zero("idle");

        rand_next(1);
        run_job(1'b0, 1'b0, 1'b0, 1'b0, "ident");

        rand_next(0);
        run_job(1'b0, 1'b0, 1'b0, 1'b0, "rand0");

        rand_next(0);
        run_job(1'b0, 1'b0, 1'b1, 1'b0, "corrupt");

        rand_next(0);
        run_job(1'b0, 1'b0, 1'b0, 1'b1, "drainpoke");
        step();
        check_outputs_zero("after poke");

        rand_next(0);
        run_job(1'b0, 1'b1, 1'b0, 1'b0, "b2b1");
        run_job(1'b1, 1'b0, 1'b0, 1'b0, "b2b2");
        step();
        check_outputs_zero("after b2b");

        // Abort at cycle 3 of a job: outputs clear at once and no done follows.
        rand_next(0);
        drive_next();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        check_outputs_zero("abort");
        step();
        rst = 1'b0;
        for (int k = 0; k < 3 * N + 2; k++) begin
            step();
            check($sformatf("abort idle%0d done", k), 64'(done), 64'd0);
            check($sformatf("abort idle%0d valid", k), 64'(valid), 64'd0);
        end

        rand_next(0);
        run_job(1'b0, 1'b0, 1'b0, 1'b0, "postabort");

        rand_next(2);
        run_job(1'b0, 1'b0, 1'b0, 1'b1, "allff");
        step();
        check_outputs_zero("after allff");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
